// File: rtl/track_recorder_pkg.sv
// Shared definitions for the note-track recorder: FSM encoding, track geometry
// and the saturating note counter helper.
package track_recorder_pkg;

  localparam int TRACK_DEPTH   = 128;
  localparam int TRACK_ADDR_W  = 7;
  localparam int LANES_DEFAULT = 4;
  localparam int LEN_W         = 8;
  localparam int NOTES_W       = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RECORD,
    ST_FLUSH,
    ST_DONE
  } rec_state_e;

  // Note total sticks at its maximum instead of wrapping.
  function automatic logic [NOTES_W-1:0] notes_sat_add(input logic [NOTES_W-1:0] total,
                                                       input logic [LEN_W-1:0]   inc);
    logic [NOTES_W:0] sum;
    sum = {1'b0, total} + {{(NOTES_W + 1 - LEN_W){1'b0}}, inc};
    return sum[NOTES_W] ? {NOTES_W{1'b1}} : sum[NOTES_W-1:0];
  endfunction

endpackage

// File: rtl/track_recorder_lane_edge_capture.sv
// Per-lane key front end: 2-flop synchronizer, optional debouncer
// (RECORD_DEBOUNCE_EN), and a one-cycle rising-edge pulse.
module lane_edge_capture #(
  parameter int LANES           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [LANES-1:0] keys_i,
  output logic [LANES-1:0] rise_o
);

  logic [LANES-1:0] sync1_q;
  logic [LANES-1:0] sync2_q;
  logic [LANES-1:0] prev_q;
  logic [LANES-1:0] level;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= keys_i;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

`ifdef RECORD_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // The filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_debounce
    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else if (sync2_q[gi] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q    <= '0;
        stable_q <= sync2_q[gi];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign level[gi] = stable_q;
  end
`else
  assign level = sync2_q;
`endif

  assign rise_o = level & ~prev_q;

endmodule

// File: rtl/track_recorder.sv
// Records lane key presses into the 128-slot note track, one lane bitmap per
// beat tick. Define RECORD_DEBOUNCE_EN to add per-lane input debouncing.
module track_recorder
  import track_recorder_pkg::*;
#(
  parameter int LANES           = LANES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    INPUTCLOCK,
  input  logic                    reset_n,
  input  logic [LANES-1:0]        keys,
  input  logic                    tick,
  input  logic                    start,
  input  logic                    stop,
  output logic                    wr_en,
  output logic [TRACK_ADDR_W-1:0] wr_addr,
  output logic [LANES-1:0]        wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    full,
  output logic [LEN_W-1:0]        length,
  output logic [NOTES_W-1:0]      notes
);

  localparam logic [TRACK_ADDR_W-1:0] LAST_SLOT = TRACK_ADDR_W'(TRACK_DEPTH - 1);

  rec_state_e              state_q, state_d;
  logic [LANES-1:0]        rise;
  logic [LANES-1:0]        slot_bits;
  logic [LANES-1:0]        acc_q, acc_d;
  logic [TRACK_ADDR_W-1:0] ptr_q, ptr_d;
  logic                    wr_en_q, wr_en_d;
  logic [TRACK_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LANES-1:0]        wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    full_q, full_d;
  logic [LEN_W-1:0]        length_q, length_d;
  logic [NOTES_W-1:0]      notes_q, notes_d;
  logic [LEN_W-1:0]        pop;
  logic                    commit;

  lane_edge_capture #(
    .LANES           (LANES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_capture (
    .clk_i  (INPUTCLOCK),
    .rst_ni (reset_n),
    .keys_i (keys),
    .rise_o (rise)
  );

  // An edge arriving in the same cycle as the tick still belongs to the slot.
  assign slot_bits = acc_q | rise;

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + LEN_W'(slot_bits[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q | rise;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    full_d    = full_q;
    length_d  = length_q;
    notes_d   = notes_q;
    commit    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_ARM;
          acc_d    = '0;
          ptr_d    = '0;
          length_d = '0;
          notes_d  = '0;
          full_d   = 1'b0;
        end
      end
      ST_ARM: begin
        if (stop) begin
          state_d = ST_DONE;
        end else if (tick) begin
          acc_d   = '0;
          state_d = ST_RECORD;
        end
      end
      ST_RECORD: begin
        if (tick) begin
          commit  = 1'b1;
          state_d = (stop || ptr_q == LAST_SLOT) ? ST_DONE : ST_RECORD;
        end else if (stop) begin
          // The partial slot is written right away; FLUSH is the write's visible cycle.
          commit  = 1'b1;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    if (commit) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = slot_bits;
      ptr_d     = ptr_q + 1'b1;
      length_d  = length_q + 1'b1;
      notes_d   = notes_sat_add(notes_q, pop);
      acc_d     = '0;
      if (ptr_q == LAST_SLOT) begin
        full_d = 1'b1;
      end
    end

    busy_d = (state_d == ST_ARM) || (state_d == ST_RECORD) || (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge INPUTCLOCK) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
      length_q  <= '0;
      notes_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      full_q    <= full_d;
      length_q  <= length_d;
      notes_q   <= notes_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign full    = full_q;
  assign length  = length_q;
  assign notes   = notes_q;

endmodule

// File: tb/tb_track_recorder.sv
// Scoreboard bench for track_recorder: stimulus pushes expected slot writes,
// a monitor pops and compares whenever wr_en is seen.
module tb_track_recorder;

  logic       INPUTCLOCK = 1'b0;
  logic       reset_n;
  logic [3:0] keys;
  logic       tick, start, stop;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [3:0] wr_data;
  logic       busy, done, full;
  logic [7:0] length;
  logic [9:0] notes;

  track_recorder dut (
    .INPUTCLOCK (INPUTCLOCK),
    .reset_n    (reset_n),
    .keys       (keys),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .length     (length),
    .notes      (notes)
  );

  always #5 INPUTCLOCK = ~INPUTCLOCK;

  typedef struct {
    int addr;
    int data;
    int len;
    int nts;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         slot;
  int         notes_m;
  logic [3:0] old_keys;
  logic [3:0] nk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every observed write must match the oldest outstanding expectation.
  always @(negedge INPUTCLOCK) begin
    exp_t e;
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data %b, no write expected", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        $display("write addr=%0d data=%b length=%0d notes=%0d", wr_addr, wr_data, length, notes);
        chk("wr_addr", int'(wr_addr), e.addr);
        chk("wr_data", int'(wr_data), e.data);
        chk("length",  int'(length),  e.len);
        chk("notes",   int'(notes),   e.nts);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge INPUTCLOCK);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  // Reference: one slot = lanes that went from released to pressed since the last slot.
  task automatic push_slot(input logic [3:0] d);
    exp_t e;
    int   total;
    total   = notes_m + $countones(d);
    notes_m = (total > 1023) ? 1023 : total;
    e.addr  = slot;
    e.data  = int'(d);
    e.len   = slot + 1;
    e.nts   = notes_m;
    sb.push_back(e);
    slot++;
  endtask

  task automatic tick_write(input logic [3:0] d);
    push_slot(d);
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic tick_stop_write(input logic [3:0] d);
    push_slot(d);
    tick = 1'b1;
    stop = 1'b1;
    step();
    tick = 1'b0;
    stop = 1'b0;
    chk("done_after_tick_stop", int'(done), 1);
    chk("busy_after_tick_stop", int'(busy), 0);
  endtask

  task automatic flush_stop(input logic [3:0] d);
    push_slot(d);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("done_in_flush", int'(done), 0);
    chk("busy_in_flush", int'(busy), 1);
    step();
    chk("done_after_flush", int'(done), 1);
    chk("busy_after_flush", int'(busy), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    slot    = 0;
    notes_m = 0;
    chk("busy_in_arm", int'(busy), 1);
  endtask

  // Keys may change while armed; whatever is pressed there is discarded.
  task automatic arm(input logic [3:0] k);
    keys     = k;
    old_keys = k;
    wait_n(6);
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic rand_slot();
    logic [3:0] press;
    if ($urandom_range(2) == 0) begin
      tick_write(4'b0000);
    end else begin
      nk       = 4'($urandom_range(15));
      press    = nk & ~old_keys;
      keys     = nk;
      old_keys = nk;
      wait_n(6 + $urandom_range(3));
      tick_write(press);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    keys     = 4'b1111;
    tick     = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    slot     = 0;
    notes_m  = 0;
    old_keys = 4'b0000;
    nk       = 4'b0000;

    // Reset with every key held.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("reset_wr_en", int'(wr_en), 0);
    end
    chk("reset_wr_addr", int'(wr_addr), 0);
    chk("reset_wr_data", int'(wr_data), 0);
    chk("reset_busy",    int'(busy),    0);
    chk("reset_done",    int'(done),    0);
    chk("reset_full",    int'(full),    0);
    chk("reset_length",  int'(length),  0);
    chk("reset_notes",   int'(notes),   0);
    reset_n = 1'b1;
    wait_n(4);
    keys = 4'b0000;
    wait_n(6);
    chk("idle_busy", int'(busy), 0);

    // Lanes 0 and 2 in slot 0, then a flush of a lane-0 press two cycles before stop.
    do_start();
    arm(4'b0000);
    chk("busy_in_record", int'(busy), 1);
    keys     = 4'b0101;
    old_keys = 4'b0101;
    wait_n(6);
    tick_write(4'b0101);
    keys = 4'b0000;
    wait_n(6);
    keys     = 4'b0001;
    old_keys = 4'b0001;
    wait_n(2);
    flush_stop(4'b0001);
    chk("len_flush", int'(length), 2);
    chk("notes_flush", int'(notes), 3);
    wait_n(3);

    // Lane 1 held across three ticks, then stop together with a tick.
    keys     = 4'b0000;
    old_keys = 4'b0000;
    wait_n(6);
    do_start();
    arm(4'b0000);
    keys     = 4'b0010;
    old_keys = 4'b0010;
    wait_n(6);
    tick_write(4'b0010);
    wait_n(3);
    tick_write(4'b0000);
    wait_n(3);
    tick_write(4'b0000);
    wait_n(2);
    tick_stop_write(4'b0000);
    wait_n(4);
    chk("len_hold", int'(length), 4);
    chk("notes_hold", int'(notes), 1);

    // Randomised recordings, alternating flush and tick+stop endings.
    for (int r = 0; r < 6; r++) begin
      int n;
      do_start();
      arm(4'($urandom_range(15)));
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) rand_slot();
      if (r % 2 == 0) begin
        logic [3:0] press;
        nk       = 4'($urandom_range(15));
        press    = nk & ~old_keys;
        keys     = nk;
        old_keys = nk;
        wait_n(6);
        flush_stop(press);
      end else begin
        tick_stop_write(4'b0000);
      end
      wait_n(3);
      chk("len_random", int'(length), n + 1);
      chk("notes_random", int'(notes), notes_m);
    end

    // Fill all 128 slots with one lane-3 press each.
    keys     = 4'b0000;
    old_keys = 4'b0000;
    wait_n(6);
    do_start();
    arm(4'b0000);
    for (int i = 0; i < 128; i++) begin
      keys = 4'b1000;
      wait_n(3);
      keys = 4'b0000;
      wait_n(3);
      tick_write(4'b1000);
    end
    chk("full_flag",  int'(full),   1);
    chk("full_done",  int'(done),   1);
    chk("full_busy",  int'(busy),   0);
    chk("full_len",   int'(length), 128);
    chk("full_notes", int'(notes),  128);
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    chk("full_addr_hold", int'(wr_addr), 127);
    chk("full_len_hold",  int'(length),  128);

    // Reset in the middle of a recording.
    do_start();
    arm(old_keys);
    for (int i = 0; i < 5; i++) rand_slot();
    wait_n(3);
    reset_n  = 1'b0;
    keys     = 4'b0000;
    old_keys = 4'b0000;
    step();
    chk("midrst_busy",   int'(busy),   0);
    chk("midrst_length", int'(length), 0);
    chk("midrst_notes",  int'(notes),  0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    reset_n = 1'b1;
    wait_n(6);
    tick = 1'b1;
    step();
    tick = 1'b0;
    wait_n(3);
    chk("idle_after_rst_busy", int'(busy), 0);
    chk("idle_after_rst_done", int'(done), 0);
    do_start();
    arm(4'b0000);
    for (int i = 0; i < 2; i++) rand_slot();
    tick_stop_write(4'b0000);
    wait_n(4);
    chk("restart_len", int'(length), 3);

    chk("pending_writes", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
